// File: rtl/fir_stream_core.sv
// Streaming FIR core: accepts one sample, runs a serial TAPS-cycle MAC, then offers the result and logs it.
// Optional FIR_SAT_EN: saturate the accumulator to the OUT_W range instead of wrapping.
module fir_stream_core #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int TAPS    = 10,
  parameter int SAMPLES = 10,
  parameter int OUT_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  input  logic [$clog2(SAMPLES)-1:0] rd_addr,
  output logic [OUT_W-1:0]           rd_data,
  output logic                       done
);
  localparam int AW    = $clog2(TAPS);
  localparam int RW    = $clog2(SAMPLES);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + $clog2(TAPS);
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nxt;

  logic signed [COEF_W-1:0] coef  [TAPS];
  logic signed [DATA_W-1:0] xline [TAPS];
  logic [OUT_W-1:0]         rbuf  [SAMPLES];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            tap;
  logic [RW-1:0]            out_cnt;
  logic signed [PW-1:0]     prod;
  logic signed [EXT_W-1:0]  acc_ext;
  logic [OUT_W-1:0]         result;
  logic                     accept, hshake, mac_last;

  assign in_ready = (state == IDLE) && !done;
  assign accept   = in_valid && in_ready;
  assign hshake   = out_valid && out_ready;
  assign mac_last = (tap == AW'(TAPS - 1));
  assign prod     = coef[tap] * xline[tap];
  assign acc_ext  = EXT_W'(acc);

`ifdef FIR_SAT_EN
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    result = acc_ext[OUT_W-1:0];
    if (acc_ext > SAT_MAX)      result = SAT_MAX[OUT_W-1:0];
    else if (acc_ext < SAT_MIN) result = SAT_MIN[OUT_W-1:0];
  end
`else
  assign result = acc_ext[OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = MAC;
      MAC:     if (mac_last) state_nxt = OUT;
      OUT:     if (hshake)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Coefficients survive reset; writes are only honoured while idle.
  always_ff @(posedge clk) begin
    if (coef_we && (state == IDLE) && (32'(coef_addr) < TAPS))
      coef[coef_addr] <= coef_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++)    xline[i] <= '0;
      for (int i = 0; i < SAMPLES; i++) rbuf[i]  <= '0;
      acc       <= '0;
      tap       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      done      <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) xline[i] <= xline[i-1];
        xline[0] <= in_data;
        acc      <= '0;
        tap      <= '0;
      end
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        tap <= mac_last ? '0 : tap + AW'(1);
      end
      // Result registered on the first OUT cycle, giving TAPS+1 cycles of latency.
      if ((state == OUT) && !out_valid) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end
      if (hshake) begin
        out_valid     <= 1'b0;
        rbuf[out_cnt] <= out_data;
        out_cnt       <= out_cnt + RW'(1);
        if (out_cnt == RW'(SAMPLES - 1)) done <= 1'b1;
      end
      rd_data <= (32'(rd_addr) < SAMPLES) ? rbuf[rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_fir_stream_core.sv
// Directed bench for fir_stream_core: impulse, latency/backpressure, coef guard, done, mid-MAC reset, overflow.
module tb_fir_stream_core;
  logic        clk = 0;
  logic        reset;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        done;

  logic        coef_we2;
  logic [3:0]  coef_addr2;
  logic [15:0] coef_data2;
  logic        in_valid2, in_ready2;
  logic [15:0] in_data2;
  logic        out_valid2, out_ready2;
  logic [15:0] out_data2;
  logic [3:0]  rd_addr2;
  logic [15:0] rd_data2;
  logic        done2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_stream_core dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .done(done)
  );

  fir_stream_core #(.OUT_W(16)) dut16 (
    .clk(clk), .reset(reset), .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_data(coef_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .done(done2)
  );

`ifdef FIR_SAT_EN
  localparam logic [15:0] EXP_Y0 = 16'h7FFF;
  localparam logic [15:0] EXP_Y9 = 16'h7FFF;
`else
  localparam logic [15:0] EXP_Y0 = 16'h0001;  // 0x7FFF^2 = 0x3FFF0001
  localparam logic [15:0] EXP_Y9 = 16'h000A;  // 10 * 0x3FFF0001 = 0x27FF6000A
`endif

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  // Offer one sample, optionally poke a coefficient during MAC, and count cycles to out_valid.
  task automatic feed(input logic [15:0] v, input bit guard, output int lat);
    int g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    in_valid = 1; in_data = v;
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      coef_we = guard && (lat == 1);
      coef_addr = 4'd0; coef_data = 16'd99;
      @(negedge clk);
      lat++;
    end
    coef_we = 0;
  endtask

  task automatic handshake();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0 || done !== 1'b0 || rd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%0d done=%b rd_data=%0d, want 1 0 0 0 0",
               in_ready, out_valid, out_data, done, rd_data);
    end
    for (int k = 0; k < 10; k++) begin
      coef_we = 1; coef_addr = 4'(k); coef_data = 16'(k + 1);
      coef_we2 = 1; coef_addr2 = 4'(k); coef_data2 = 16'h7FFF;
      @(negedge clk);
    end
    coef_we = 0; coef_we2 = 0;
  endtask

  task automatic test_latency_backpressure();
    int lat;
    feed(16'd1, 0, lat);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL latency: got %0d cycles, want 11", lat); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: out_valid=%b out_data=%0d in_ready=%b, want 1 1 0", c, out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    handshake();
  endtask

  task automatic test_impulse_coef_guard();
    int lat;
    for (int n = 1; n < 10; n++) begin
      feed(16'd0, n == 1, lat);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(n + 1)) begin
        errors++;
        $display("FAIL impulse[%0d]: out_valid=%b out_data=%0d, want 1 %0d", n, out_valid, out_data, n + 1);
      end
      handshake();
    end
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_set: done=%b in_ready=%b, want 1 0", done, in_ready);
    end
  endtask

  task automatic test_done();
    int seen = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c % 4 == 0); in_data = 16'd5;
      @(negedge clk);
      if (out_valid || in_ready || !done) seen++;
    end
    in_valid = 0;
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL done_hold: %0d bad cycles, want 0", seen); end
    for (int i = 0; i < 10; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      checks++;
      if (rd_data !== 32'(i + 1)) begin
        errors++;
        $display("FAIL buffer[%0d]: got %0d want %0d", i, rd_data, i + 1);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    int lat;
    do_reset();
    rd_addr = 4'd0;
    in_valid = 1; in_data = 16'd1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || rd_data !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_mac_reset: out_valid=%b done=%b rd_data=%0d in_ready=%b, want 0 0 0 1",
               out_valid, done, rd_data, in_ready);
    end
    lat = 0;
    for (int c = 0; c < 15; c++) begin @(negedge clk); if (out_valid) lat++; end
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL stale_result: out_valid seen %0d cycles, want 0", lat); end
    feed(16'd1, 0, lat);
    checks++;
    if (lat !== 11 || out_data !== 32'd1) begin
      errors++;
      $display("FAIL coef_retained: lat=%0d out_data=%0d, want 11 1", lat, out_data);
    end
    handshake();
    feed(16'd0, 0, lat);
    checks++;
    if (out_data !== 32'd2) begin errors++; $display("FAIL coef_retained_k1: got %0d want 2", out_data); end
    handshake();
    @(negedge clk);
    checks++;
    if (rd_data !== 32'd1) begin errors++; $display("FAIL buffer_after_reset: got %0d want 1", rd_data); end
  endtask

  task automatic test_overflow();
    logic [15:0] y0, y9;
    int g;
    do_reset();
    y0 = '0; y9 = '0;
    for (int n = 0; n < 10; n++) begin
      in_valid2 = 1; in_data2 = 16'h7FFF;
      @(negedge clk);
      in_valid2 = 0;
      g = 0;
      while (!out_valid2 && g < 40) begin @(negedge clk); g++; end
      if (n == 0) y0 = out_data2;
      if (n == 9) y9 = out_data2;
      out_ready2 = 1;
      @(negedge clk);
      out_ready2 = 0;
    end
    checks++;
    if (y0 !== EXP_Y0) begin errors++; $display("FAIL overflow_y0: got %h want %h", y0, EXP_Y0); end
    checks++;
    if (y9 !== EXP_Y9) begin errors++; $display("FAIL overflow_y9: got %h want %h", y9, EXP_Y9); end
    checks++;
    if (done2 !== 1'b1) begin errors++; $display("FAIL overflow_done: got %b want 1", done2); end
  endtask

  initial begin
    reset = 1; coef_we = 0; coef_addr = 0; coef_data = 0;
    in_valid = 0; in_data = 0; out_ready = 0; rd_addr = 0;
    coef_we2 = 0; coef_addr2 = 0; coef_data2 = 0;
    in_valid2 = 0; in_data2 = 0; out_ready2 = 0; rd_addr2 = 0;
    @(negedge clk);
    test_reset();
    test_latency_backpressure();
    test_impulse_coef_guard();
    test_done();
    test_reset_mid_mac();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_stream_core.md
FIR_STREAM_CORE -- requirements
Module: fir_stream_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed sample width.
REQ-002 SHALL have parameter COEF_W, default 16, signed coefficient width.
REQ-003 SHALL have parameter TAPS, default 10, filter length, legal range 2..64.
REQ-004 SHALL have parameter SAMPLES, default 10, samples per run and result-buffer depth.
REQ-005 SHALL have parameter OUT_W, default 32, signed output width.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port coef_we  input  1  coefficient write strobe.
REQ-009 SHALL have port coef_addr  input  $clog2(TAPS)  coefficient index.
REQ-010 SHALL have port coef_data  input  COEF_W  coefficient value.
REQ-011 SHALL have port in_valid  input  1  sample offered.
REQ-012 SHALL have port in_ready  output  1  sample accepted when high with in_valid.
REQ-013 SHALL have port in_data  input  DATA_W  sample value.
REQ-014 SHALL have port out_valid  output  1  result available.
REQ-015 SHALL have port out_ready  input  1  sink accepts result.
REQ-016 SHALL have port out_data  output  OUT_W  filter result.
REQ-017 SHALL have port rd_addr  input  $clog2(SAMPLES)  result-buffer read index.
REQ-018 SHALL have port rd_data  output  OUT_W  result-buffer read data.
REQ-019 SHALL have port done  output  1  run of SAMPLES outputs complete.

Function
REQ-020 SHALL implement states IDLE, MAC, OUT; IDLE->MAC on accepted sample; MAC->OUT after TAPS cycles; OUT->IDLE on out_valid&&out_ready.
REQ-021 SHALL drive in_ready=1 only in IDLE with done=0.
REQ-022 SHALL, on acceptance, shift in_data into a TAPS-deep delay line (x[n] at index 0) and clear the accumulator.
REQ-023 SHALL in MAC add coef[k]*x[n-k] for k=0..TAPS-1, one tap per cycle, using a signed accumulator of DATA_W+COEF_W+$clog2(TAPS) bits.
REQ-024 SHALL assert out_valid exactly TAPS+1 cycles after the acceptance edge, absent reset.
REQ-025 SHALL hold out_valid and out_data stable while out_ready=0; no new sample is accepted meanwhile.
REQ-026 SHALL write out_data into result buffer entry n (n = 0-based output count) on the out handshake edge.
REQ-027 SHALL set done=1 on the handshake of output SAMPLES-1; done is sticky until reset; in_valid is ignored while done=1.
REQ-028 SHALL accept coef_we writes only in IDLE; writes in MAC or OUT are discarded without effect.
REQ-029 SHALL register rd_data: value at buffer[rd_addr] appears one cycle after rd_addr; unwritten entries read 0; reads are legal in every state.
REQ-030 SHALL give out_data as accumulator low OUT_W bits (two's-complement wrap) when FIR_SAT_EN is undefined.

Reset
REQ-031 SHALL on reset, including mid-MAC or mid-OUT, force IDLE, in_ready=1, out_valid=0, out_data=0, done=0, rd_data=0, output count=0.
REQ-032 SHALL on reset clear delay line and result buffer to 0; coefficients SHALL retain their values.
REQ-033 SHALL drop any in-flight result on reset; no buffer write occurs in the reset cycle.

Configuration
REQ-034 SHALL, with FIR_SAT_EN defined, saturate the accumulator to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before out_data and buffer write.
REQ-035 SHALL, without FIR_SAT_EN, wrap per REQ-030 and include no saturation logic.

Verification
REQ-036 Impulse: coef[k]=k+1, samples 1,0,0,...(10) -> out_data 1,2,...,10; buffer[0..9]=1..10; done=1.
REQ-037 Latency/backpressure: accept at cycle t -> out_valid at t+11 (TAPS=10); out_ready=0 for 5 cycles -> out_data stable, in_ready=0.
REQ-038 Coef guard: coef_we with coef_addr=0, data 99 during MAC -> next impulse response still starts with 1.
REQ-039 Done: after 10th handshake done=1, in_ready=0; extra in_valid pulses -> no out_valid, buffer unchanged.
REQ-040 Reset mid-MAC: reset 3 cycles after acceptance -> next cycle out_valid=0, done=0, rd_data=0; coefficients intact.
REQ-041 Overflow, OUT_W=16, all coef=0x7FFF, all samples=0x7FFF: FIR_SAT_EN -> 0x7FFF; without -> low 16 bits of exact sum.
